// File: rtl/fpga_ram_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpga_ram_arb_pkg
// Purpose  : Shared types and helpers for the RAM read arbiter.
//            - rr_pointer_t : round-robin pointer
//            - rr_pick      : first-eligible search from the pointer, with wrap
//            - RR_ASSERT_TAG: prefix for simulation assertion messages
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fpga_ram_arb_pkg;

  // Upper bound on the reader count.
  // The pointer and search vector are sized for this bound, so one type
  // serves every instance.
  localparam int RR_MAX_READERS = 16;
  localparam int RR_PTR_W       = $clog2(RR_MAX_READERS);

  typedef logic [RR_PTR_W-1:0]       rr_pointer_t;
  typedef logic [RR_MAX_READERS-1:0] rr_vec_t;

  typedef struct packed {
    logic        found;
    rr_pointer_t idx;
  } rr_pick_t;

  localparam string RR_ASSERT_TAG = "fpga_ram_read_arbiter";

  // Search upward from ptr, modulo n, for the first set bit of elig.
  // ptr is always < n, so a single subtraction is enough for the wrap.
  function automatic rr_pick_t rr_pick(input rr_vec_t     elig,
                                       input int          n,
                                       input rr_pointer_t ptr);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 0; k < RR_MAX_READERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !r.found && elig[idx[RR_PTR_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[RR_PTR_W-1:0];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_ram_1c_1w_1r.sv
`default_nettype none
// ============================================================================
// Module   : fpga_ram_1c_1w_1r
// Purpose  : Single-clock block RAM with one write port and one
//            registered read port. Contents are not reset.
// Ports    : clk          - clock
//            wr_en_i      - write strobe
//            wr_address_i - write address
//            wr_data_i    - write data
//            rd_en_i      - read strobe; loads rd_data_o at the next edge
//            rd_address_i - read address
//            rd_data_o    - registered read data (old data on same-address RW)
// Revision : 1.0 - initial release
// ============================================================================
module fpga_ram_1c_1w_1r #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] wr_address_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_address_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_address_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_address_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fpga_ram_read_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_pick
// Purpose  : Combinational round-robin pick.
//            Takes an eligibility vector and a pointer.
//            Returns a one-hot grant: the first eligible requester at or
//            after the pointer.
// Ports    : eligible_i - per-requester eligibility
//            pointer_i  - highest-priority requester index (< NR_OF_READERS)
//            grant_o    - one-hot grant, zero when nothing is eligible
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_pick
  import fpga_ram_arb_pkg::*;
#(
  parameter int NR_OF_READERS = 4
) (
  input  logic [NR_OF_READERS-1:0] eligible_i,
  input  rr_pointer_t              pointer_i,
  output logic [NR_OF_READERS-1:0] grant_o
);

  rr_vec_t  w_elig_wide;
  rr_pick_t w_pick;

  always_comb begin
    w_elig_wide                      = '0;
    w_elig_wide[NR_OF_READERS-1:0]   = eligible_i;
  end

  assign w_pick = rr_pick(w_elig_wide, NR_OF_READERS, pointer_i);

  generate
    for (genvar gi = 0; gi < NR_OF_READERS; gi++) begin : g_grant
      assign grant_o[gi] = w_pick.found && (w_pick.idx == rr_pointer_t'(gi));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fpga_ram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpga_ram_read_arbiter
// Purpose  : Shares the read port of a 1-clock 1W/1R block RAM between
//            nr_of_readers_p requesters with round-robin arbitration.
//            A read whose address matches a same-cycle write is stalled.
//            With FPGA_RAM_ARB_WR_BYPASS_EN defined, that read is instead
//            served the write data through a registered bypass.
// Ports    : clk          - clock
//            rst_n        - asynchronous active-low reset
//            wr_en        - write strobe, always accepted
//            wr_address   - write address
//            wr_data      - write data
//            rd_req       - per-reader request level
//            rd_address   - per-reader read address (packed array)
//            rd_ack       - one-hot grant, combinational
//            rd_rsp_valid - one-hot response valid, one cycle after rd_ack
//            rd_rsp_data  - shared response data, qualified by rd_rsp_valid
// Config   : `define FPGA_RAM_ARB_WR_BYPASS_EN enables write-to-read bypass
// Revision : 1.0 - initial release
// ============================================================================
module fpga_ram_read_arbiter
  import fpga_ram_arb_pkg::*;
#(
  parameter int nr_of_readers_p = 4,
  parameter int data_width_p    = 32,
  parameter int address_width_p = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            wr_en,
  input  logic [address_width_p-1:0]                      wr_address,
  input  logic [data_width_p-1:0]                         wr_data,
  input  logic [nr_of_readers_p-1:0]                      rd_req,
  input  logic [nr_of_readers_p-1:0][address_width_p-1:0] rd_address,
  output logic [nr_of_readers_p-1:0]                      rd_ack,
  output logic [nr_of_readers_p-1:0]                      rd_rsp_valid,
  output logic [data_width_p-1:0]                         rd_rsp_data
);

  logic                       w_wr_en;
  logic [nr_of_readers_p-1:0] w_eligible;
  logic [nr_of_readers_p-1:0] w_grant;
  logic [nr_of_readers_p-1:0] w_ack;
  logic                       w_any_ack;
  logic [address_width_p-1:0] w_rd_addr;
  logic [data_width_p-1:0]    w_ram_rd_data;

  rr_pointer_t                ptr_q, ptr_d;
  logic [nr_of_readers_p-1:0] rsp_valid_q;

  assign w_wr_en = wr_en & rst_n;

  // A read colliding with the current write is held back.
  // Otherwise it would sample a RAM word in the middle of being written.
  // In bypass builds the write data is forwarded instead.
  generate
    for (genvar gi = 0; gi < nr_of_readers_p; gi++) begin : g_elig
`ifdef FPGA_RAM_ARB_WR_BYPASS_EN
      assign w_eligible[gi] = rd_req[gi];
`else
      assign w_eligible[gi] = rd_req[gi] &&
                              !(w_wr_en && (rd_address[gi] == wr_address));
`endif
    end
  endgenerate

  rr_arbiter_pick #(
    .NR_OF_READERS (nr_of_readers_p)
  ) u_pick (
    .eligible_i (w_eligible),
    .pointer_i  (ptr_q),
    .grant_o    (w_grant)
  );

  assign w_ack     = w_grant & {nr_of_readers_p{rst_n}};
  assign w_any_ack = |w_ack;
  assign rd_ack    = w_ack;

  always_comb begin
    w_rd_addr = '0;
    for (int i = 0; i < nr_of_readers_p; i++) begin
      if (w_ack[i]) w_rd_addr = rd_address[i];
    end
  end

  // Winner moves to lowest priority; the pointer holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < nr_of_readers_p; i++) begin
      if (w_ack[i]) ptr_d = (i == nr_of_readers_p - 1) ? '0 : rr_pointer_t'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= w_ack;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;

  fpga_ram_1c_1w_1r #(
    .DATA_WIDTH    (data_width_p),
    .ADDRESS_WIDTH (address_width_p)
  ) u_ram (
    .clk          (clk),
    .wr_en_i      (w_wr_en),
    .wr_address_i (wr_address),
    .wr_data_i    (wr_data),
    .rd_en_i      (w_any_ack),
    .rd_address_i (w_rd_addr),
    .rd_data_o    (w_ram_rd_data)
  );

`ifdef FPGA_RAM_ARB_WR_BYPASS_EN
  // The RAM returns old data on a same-address read/write.
  // The bypass register captures the new write data, so the granted reader
  // sees new-data semantics at the same latency.
  logic                    byp_sel_q, byp_sel_d;
  logic [data_width_p-1:0] byp_data_q;

  assign byp_sel_d = w_any_ack && w_wr_en && (w_rd_addr == wr_address);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byp_sel_q <= 1'b0;
    else        byp_sel_q <= byp_sel_d;
  end

  always_ff @(posedge clk) begin
    if (byp_sel_d) byp_data_q <= wr_data;
  end

  assign rd_rsp_data = byp_sel_q ? byp_data_q : w_ram_rd_data;
`else
  assign rd_rsp_data = w_ram_rd_data;
`endif

`ifndef SYNTHESIS
  // A requester must hold rd_req until it is acknowledged.
  generate
    for (genvar gi = 0; gi < nr_of_readers_p; gi++) begin : g_req_hold_chk
      a_req_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (rd_req[gi] && !rd_ack[gi]) |=> rd_req[gi])
        else $error("%s: reader %0d dropped rd_req before rd_ack", RR_ASSERT_TAG, gi);
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpga_ram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_ram_read_arbiter
// Purpose  : Directed self-checking bench for fpga_ram_read_arbiter
//            (N=4, DW=32, AW=8).
//            Inputs change on the falling edge.
//            rd_ack is checked 1 time unit later.
//            Responses are checked on the falling edge after the grant edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_ram_read_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;

  logic                 clk        = 1'b0;
  logic                 rst_n      = 1'b0;
  logic                 wr_en      = 1'b0;
  logic [AW-1:0]        wr_address = '0;
  logic [DW-1:0]        wr_data    = '0;
  logic [N-1:0]         rd_req     = '0;
  logic [N-1:0][AW-1:0] rd_address = '0;
  logic [N-1:0]         rd_ack;
  logic [N-1:0]         rd_rsp_valid;
  logic [DW-1:0]        rd_rsp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpga_ram_read_arbiter #(
    .nr_of_readers_p (N),
    .data_width_p    (DW),
    .address_width_p (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_address   (wr_address),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_address   (rd_address),
    .rd_ack       (rd_ack),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data)
  );

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; wr_en = 1'b0; rd_req = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_req = '1;
    @(negedge clk); #1;
    total++; if (rd_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", rd_ack); end
    total++; if (rd_rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rd_rsp_valid); end
    @(negedge clk); rd_req = '0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    total++; if (rd_ack !== 4'b0000) begin bad++; $display("FAIL idle_ack: got %b want 0000", rd_ack); end
  endtask

  task automatic test_write_read();
    @(negedge clk); wr_en = 1'b1; wr_address = 8'd5; wr_data = 32'h0000_0011;
    @(negedge clk); wr_en = 1'b0; rd_address[0] = 8'd5; rd_req = 4'b0001;
    #1;
    total++; if (rd_ack !== 4'b0001) begin bad++; $display("FAIL wr_rd_ack: got %b want 0001", rd_ack); end
    @(negedge clk); rd_req = '0;
    #1;
    total++; if (rd_rsp_valid !== 4'b0001) begin bad++; $display("FAIL wr_rd_valid: got %b want 0001", rd_rsp_valid); end
    total++; if (rd_rsp_data !== 32'h0000_0011) begin bad++; $display("FAIL wr_rd_data: got %h want 00000011", rd_rsp_data); end
    total++; if (rd_ack !== 4'b0000) begin bad++; $display("FAIL wr_rd_noack: got %b want 0000", rd_ack); end
    @(negedge clk); #1;
    total++; if (rd_rsp_valid !== 4'b0000) begin bad++; $display("FAIL wr_rd_valid_once: got %b want 0000", rd_rsp_valid); end
  endtask

  // All four readers request at once with the pointer at 0.
  // Each reader drops its request in the cycle after its own ack.
  task automatic test_simultaneous();
    logic [N-1:0] exp_ack;
    logic [N-1:0] exp_vld;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_address = AW'(i + 1); wr_data = 32'hA1 + DW'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) rd_address[i] = AW'(i + 1);
    rd_req = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_ack = N'(1 << k);
      total++; if (rd_ack !== exp_ack) begin bad++; $display("FAIL simul_ack[%0d]: got %b want %b", k, rd_ack, exp_ack); end
      if (k > 0) begin
        exp_vld = N'(1 << (k - 1));
        total++; if (rd_rsp_valid !== exp_vld) begin bad++; $display("FAIL simul_valid[%0d]: got %b want %b", k, rd_rsp_valid, exp_vld); end
        total++; if (rd_rsp_data !== 32'hA0 + DW'(k)) begin bad++; $display("FAIL simul_data[%0d]: got %h want %h", k, rd_rsp_data, 32'hA0 + DW'(k)); end
      end
      @(negedge clk); rd_req = rd_req & ~exp_ack;
    end
    #1;
    total++; if (rd_rsp_valid !== 4'b1000) begin bad++; $display("FAIL simul_valid_last: got %b want 1000", rd_rsp_valid); end
    total++; if (rd_rsp_data !== 32'hA4) begin bad++; $display("FAIL simul_data_last: got %h want 000000a4", rd_rsp_data); end
  endtask

  // Readers 1 (addr 2 -> A2) and 3 (addr 4 -> A4) request continuously
  // while the pointer starts at 0.
  task automatic test_round_robin();
    logic [N-1:0] exp_ack;
    logic [N-1:0] prev_ack;
    prev_ack = '0;
    @(negedge clk); rd_address[1] = 8'd2; rd_address[3] = 8'd4; rd_req = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_ack = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      total++; if (rd_ack !== exp_ack) begin bad++; $display("FAIL rr_ack[%0d]: got %b want %b", k, rd_ack, exp_ack); end
      if (k > 0) begin
        total++; if (rd_rsp_valid !== prev_ack) begin bad++; $display("FAIL rr_valid[%0d]: got %b want %b", k, rd_rsp_valid, prev_ack); end
        total++; if (rd_rsp_data !== ((prev_ack == 4'b0010) ? 32'hA2 : 32'hA4)) begin bad++; $display("FAIL rr_data[%0d]: got %h", k, rd_rsp_data); end
      end
      prev_ack = exp_ack;
      @(negedge clk);
    end
    // Reader 3 was just served; reader 1 is still pending and must be served next.
    rd_req = 4'b0010;
    #1;
    total++; if (rd_ack !== 4'b0010) begin bad++; $display("FAIL rr_tail_ack: got %b want 0010", rd_ack); end
    total++; if (rd_rsp_data !== 32'hA4) begin bad++; $display("FAIL rr_tail_data: got %h want 000000a4", rd_rsp_data); end
    @(negedge clk); rd_req = '0;
    #1;
    total++; if (rd_rsp_valid !== 4'b0010) begin bad++; $display("FAIL rr_end_valid: got %b want 0010", rd_rsp_valid); end
    total++; if (rd_rsp_data !== 32'hA2) begin bad++; $display("FAIL rr_end_data: got %h want 000000a2", rd_rsp_data); end
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp7;
    @(negedge clk); wr_en = 1'b1; wr_address = 8'd7; wr_data = 32'hAA; rd_address[2] = 8'd7; rd_req = 4'b0100;
`ifdef FPGA_RAM_ARB_WR_BYPASS_EN
    #1;
    total++; if (rd_ack !== 4'b0100) begin bad++; $display("FAIL byp_ack: got %b want 0100", rd_ack); end
    @(negedge clk); wr_en = 1'b0; rd_req = '0;
    #1;
    total++; if (rd_rsp_valid !== 4'b0100) begin bad++; $display("FAIL byp_valid: got %b want 0100", rd_rsp_valid); end
    total++; if (rd_rsp_data !== 32'hAA) begin bad++; $display("FAIL byp_data: got %h want 000000aa", rd_rsp_data); end
    exp7 = 32'hAA;
`else
    #1;
    total++; if (rd_ack !== 4'b0000) begin bad++; $display("FAIL stall_ack0: got %b want 0000", rd_ack); end
    @(negedge clk); wr_data = 32'hBB;
    #1;
    total++; if (rd_ack !== 4'b0000) begin bad++; $display("FAIL stall_ack1: got %b want 0000", rd_ack); end
    total++; if (rd_rsp_valid !== 4'b0000) begin bad++; $display("FAIL stall_valid1: got %b want 0000", rd_rsp_valid); end
    @(negedge clk); wr_en = 1'b0;
    #1;
    total++; if (rd_ack !== 4'b0100) begin bad++; $display("FAIL stall_release_ack: got %b want 0100", rd_ack); end
    @(negedge clk); rd_req = '0;
    #1;
    total++; if (rd_rsp_valid !== 4'b0100) begin bad++; $display("FAIL stall_valid: got %b want 0100", rd_rsp_valid); end
    total++; if (rd_rsp_data !== 32'hBB) begin bad++; $display("FAIL stall_data: got %h want 000000bb", rd_rsp_data); end
    exp7 = 32'hBB;
`endif
    // A write to a different address must not hold back the read.
    @(negedge clk); wr_en = 1'b1; wr_address = 8'd9; wr_data = 32'h99; rd_address[0] = 8'd7; rd_req = 4'b0001;
    #1;
    total++; if (rd_ack !== 4'b0001) begin bad++; $display("FAIL nocoll_ack: got %b want 0001", rd_ack); end
    @(negedge clk); wr_en = 1'b0; rd_req = '0;
    #1;
    total++; if (rd_rsp_valid !== 4'b0001) begin bad++; $display("FAIL nocoll_valid: got %b want 0001", rd_rsp_valid); end
    total++; if (rd_rsp_data !== exp7) begin bad++; $display("FAIL nocoll_data: got %h want %h", rd_rsp_data, exp7); end
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] exp_ack;
    @(negedge clk); rd_address[1] = 8'd2; rd_req = 4'b0010;
    #1;
    total++; if (rd_ack !== 4'b0010) begin bad++; $display("FAIL mr_ack: got %b want 0010", rd_ack); end
    @(posedge clk); #1;
    total++; if (rd_rsp_valid !== 4'b0010) begin bad++; $display("FAIL mr_valid_pre: got %b want 0010", rd_rsp_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (rd_rsp_valid !== 4'b0000) begin bad++; $display("FAIL mr_valid_cleared: got %b want 0000", rd_rsp_valid); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) rd_address[i] = AW'(i + 1);
    rd_req = '1;
    #1;
    total++; if (rd_ack !== 4'b0000) begin bad++; $display("FAIL mr_ack_in_reset: got %b want 0000", rd_ack); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_ack = N'(1 << k);
      total++; if (rd_ack !== exp_ack) begin bad++; $display("FAIL mr_ack[%0d]: got %b want %b", k, rd_ack, exp_ack); end
      if (k > 0) begin
        total++; if (rd_rsp_data !== 32'hA0 + DW'(k)) begin bad++; $display("FAIL mr_data[%0d]: got %h want %h", k, rd_rsp_data, 32'hA0 + DW'(k)); end
      end
      @(negedge clk); rd_req = rd_req & ~exp_ack;
    end
    #1;
    total++; if (rd_rsp_valid !== 4'b1000) begin bad++; $display("FAIL mr_valid_last: got %b want 1000", rd_rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_round_robin();
    test_collision();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
